// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl #(
  parameter int INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    REFILL
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];
  logic [26:0]      miss_blk_q;
  logic [255:0]     fill_q;

  logic [INDEX_W-1:0] cpu_idx;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [TAG_W-1:0]   miss_tag;
  logic [2:0]         cpu_word;
  logic               hit;
  logic               srv;
  logic               store_hit;
  logic               miss_start;
  logic               unused_addr;

  assign cpu_idx     = cpu_addr_i[5+:INDEX_W];
  assign cpu_tag     = cpu_addr_i[31:5+INDEX_W];
  assign cpu_word    = cpu_addr_i[4:2];
  assign miss_idx    = miss_blk_q[INDEX_W-1:0];
  assign miss_tag    = miss_blk_q[26:INDEX_W];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & valid_q[cpu_idx]
             & (tag_q[cpu_idx] == cpu_tag);
  assign srv        = (state_q == IDLE) & hit;
  assign store_hit  = srv & cpu_write_i;
  assign miss_start = (state_q == IDLE) & cpu_req_i & ~hit;

  assign cpu_stall_o = cpu_req_i & ~srv;
  assign cpu_data_o  = (srv & ~cpu_write_i)
                     ? data_q[cpu_idx][{cpu_word, 5'd0} +: 32]
                     : 32'd0;

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (miss_start)
          state_d = (valid_q[cpu_idx] & dirty_q[cpu_idx])
                  ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[miss_idx], miss_idx, 5'd0};
        mem_data_o   = data_q[miss_idx];
        if (mem_ack_i)
          state_d = FETCH;
      end
      FETCH: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_blk_q, 5'd0};
        if (mem_ack_i)
          state_d = REFILL;
      end
      REFILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_blk_q <= '0;
      fill_q     <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start)
        miss_blk_q <= cpu_addr_i[31:5];
      if (state_q == FETCH && mem_ack_i)
        fill_q <= mem_data_i;
      if (store_hit)
        dirty_q[cpu_idx] <= 1'b1;
      if (state_q == REFILL) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Line storage carries no reset; valid_q gates every use.
  always_ff @(posedge clk_i) begin
    if (state_q == REFILL) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= fill_q;
    end else if (store_hit) begin
      data_q[cpu_idx][{cpu_word, 5'd0} +: 32] <= cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_refill_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o      <= '0;
      miss_cnt_o     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      after_refill_q <= (state_q == REFILL);
      if (srv && !after_refill_q)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss_start)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed + random checks of dcache_ctrl against a
// flat-memory golden model and a tag/valid/dirty directory model.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_write_i (cpu_write_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  int checks = 0;
  int errors = 0;

  // bmem: backing memory; gold: architectural view of memory
  logic [31:0] bmem [int];
  logic [31:0] gold [int];
  bit          mv [16];
  bit          md [16];
  int          mt [16];

  logic [31:0]  last_rd;
  logic [255:0] last_wb;
  logic [31:0]  last_wa;
  logic [31:0]  last_fa;

  function automatic logic [31:0] init_w(int wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] mem_rd(int wa);
    if (bmem.exists(wa)) return bmem[wa];
    return init_w(wa);
  endfunction

  function automatic logic [31:0] gold_rd(int wa);
    if (gold.exists(wa)) return gold[wa];
    return mem_rd(wa);
  endfunction

  function automatic logic [255:0] mem_blk(int ba);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = mem_rd(ba * 8 + i);
    return b;
  endfunction

  function automatic logic [255:0] gold_blk(int ba);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = gold_rd(ba * 8 + i);
    return b;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_cyc(bit stray);
    cpu_req_i  = 1'b0;
    mem_ack_i  = stray;
    mem_data_i = {8{$urandom}};
    @(negedge clk_i);
    chk("idle_stall", cpu_stall_o, 0);
    chk("idle_en", mem_enable_o, 0);
    chk("idle_rdata", cpu_data_o, 0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
  endtask

  task automatic mem_cyc(bit wr, logic [31:0] a, logic [255:0] d,
                         bit ack, logic [255:0] rdat);
    mem_ack_i  = ack;
    mem_data_i = rdat;
    @(negedge clk_i);
    chk("mem_en", mem_enable_o, 1);
    chk("mem_we", mem_write_o, wr);
    chk("mem_addr", mem_addr_o, a);
    if (wr) chk("wb_data", mem_data_o, d);
    chk("mem_stall", cpu_stall_o, cpu_req_i);
    chk("mem_rdata", cpu_data_o, 0);
    if (wr) begin
      last_wb = mem_data_o;
      last_wa = mem_addr_o;
    end else begin
      last_fa = mem_addr_o;
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
  endtask

  task automatic access(bit wr, logic [31:0] a, logic [31:0] d,
                        int dwb, int df, bit drop);
    int idx;
    int tg;
    int blk;
    int wa;
    int vb;
    logic [255:0] vd;
    idx = int'(a[8:5]);
    tg  = int'(a[31:9]);
    blk = int'(a[31:5]);
    wa  = int'(a[31:2]);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = a;
    cpu_data_i  = d;
    if (!(mv[idx] && mt[idx] == tg)) begin
      @(negedge clk_i);
      chk("miss_stall", cpu_stall_o, 1);
      chk("miss_en", mem_enable_o, 0);
      chk("miss_rdata", cpu_data_o, 0);
      @(posedge clk_i); #1;
      if (drop) cpu_req_i = 1'b0;
      if (mv[idx] && md[idx]) begin
        vb = mt[idx] * 16 + idx;
        vd = gold_blk(vb);
        for (int k = 0; k <= dwb; k++)
          mem_cyc(1'b1, 32'(vb << 5), vd, k == dwb, {8{$urandom}});
        for (int i = 0; i < 8; i++) bmem[vb * 8 + i] = vd[32*i +: 32];
      end
      for (int k = 0; k <= df; k++)
        mem_cyc(1'b0, 32'(blk << 5), '0, k == df, mem_blk(blk));
      @(negedge clk_i);
      chk("refill_en", mem_enable_o, 0);
      chk("refill_we", mem_write_o, 0);
      chk("refill_stall", cpu_stall_o, cpu_req_i);
      @(posedge clk_i); #1;
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tg;
      if (drop) return;
    end
    @(negedge clk_i);
    chk("hit_stall", cpu_stall_o, 0);
    chk("hit_en", mem_enable_o, 0);
    chk("hit_rdata", cpu_data_o, wr ? 32'd0 : gold_rd(wa));
    last_rd = cpu_data_o;
    @(posedge clk_i); #1;
    if (wr) begin
      gold[wa] = d;
      md[idx]  = 1'b1;
    end
    cpu_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = 0;
    end
    @(negedge clk_i);
    chk("rst_en", mem_enable_o, 0);
    chk("rst_we", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_rdata", cpu_data_o, 0);
    chk("rst_stall", cpu_stall_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    bmem[32'h48 >> 2] = 32'hDEAD_BEEF;
    access(1'b0, 32'h40, 0, 0, 2, 1'b0);
    chk("lit_fetch_addr", last_fa, 32'h40);
    access(1'b0, 32'h48, 0, 0, 0, 1'b0);
    chk("lit_deadbeef", last_rd, 32'hDEAD_BEEF);
    access(1'b1, 32'h44, 32'h1234_5678, 0, 0, 1'b0);
    access(1'b0, 32'h44, 0, 0, 0, 1'b0);
    chk("lit_store_load", last_rd, 32'h1234_5678);
    access(1'b0, 32'h240, 0, 1, 10, 1'b0);
    chk("lit_wb_addr", last_wa, 32'h40);
    chk("lit_wb_word1", last_wb[63:32], 32'h1234_5678);
    chk("lit_fetch2", last_fa, 32'h240);

    // dirty the 0x240 line, then reset in the middle of its write-back
    access(1'b1, 32'h244, 32'hCAFE_F00D, 0, 0, 1'b0);
    cpu_req_i   = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i  = 32'h444;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rwb_en", mem_enable_o, 1);
    chk("rwb_addr", mem_addr_o, 32'h240);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_en", mem_enable_o, 0);
    chk("rst_mid_addr", mem_addr_o, 0);
    chk("rst_mid_data", mem_data_o, 0);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    gold.delete();
    idle_cyc(1'b1);
    idle_cyc(1'b0);
    access(1'b0, 32'h244, 0, 0, 1, 1'b0);
    chk("lit_refetch", last_fa, 32'h240);
    chk("lit_discard", last_rd, init_w(32'h244 >> 2));

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cyc(1'($urandom_range(0, 1)));
      end else begin
        a = (32'($urandom_range(0, 3)) << 9)
          | (32'($urandom_range(0, 15)) << 5)
          | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
        access(1'($urandom_range(0, 1)), a, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 9) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
